// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution window generator.
//   - state_t            : frame controller states (IDLE, RUN)
//   - D0..D8             : window tap indices, row-major, D0 = top-left,
//                          D8 = bottom-right (D0 sits in the LSBs of win_data)
//   - CONV_DEFAULT_MAX_W : default maximum image width in pixels
//   - CONV_DEFAULT_PIX_W : default pixel width in bits
//   - win_idx()          : maps (row, col) inside the 3x3 window to a tap index
package conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int D0 = 0;
  localparam int D1 = 1;
  localparam int D2 = 2;
  localparam int D3 = 3;
  localparam int D4 = 4;
  localparam int D5 = 5;
  localparam int D6 = 6;
  localparam int D7 = 7;
  localparam int D8 = 8;

  localparam int CONV_DEFAULT_MAX_W = 64;
  localparam int CONV_DEFAULT_PIX_W = 8;

  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: one image line of storage.
//   Single synchronous write port and an asynchronous (combinational) read
//   port, so a read and a write at the same address in one cycle return the
//   old contents (read-before-write). Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
module conv_line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into a stream of 3x3
// windows (no border padding). One window per interior pixel, full
// throughput of one pixel per cycle when the output is not stalled.
//
// Optional feature: define CONV_WIN_PERF_CNT_EN to add the win_count output,
// a saturating count of accepted windows cleared by rst and by start.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle pulse, latches img_w/img_h and begins a frame
//   img_w      in   frame width in pixels (3..MAX_W)
//   img_h      in   frame height in rows (>=3)
//   pix_valid  in   input pixel valid
//   pix_ready  out  input pixel ready
//   pix_data   in   input pixel
//   win_valid  out  window valid
//   win_ready  in   window ready
//   win_data   out  window, D0 in the LSBs, D8 in the MSBs
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last window is accepted
//   win_count  out  accepted-window counter (CONV_WIN_PERF_CNT_EN only)
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int MAX_W = CONV_DEFAULT_MAX_W,
  parameter int PIX_W = CONV_DEFAULT_PIX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [$clog2(MAX_W):0] img_w,
  input  logic [15:0]            img_h,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [9*PIX_W-1:0]     win_data,
  output logic                   busy,
  output logic                   done
`ifdef CONV_WIN_PERF_CNT_EN
  ,
  output logic [31:0]            win_count
`endif
);

  localparam int CW = $clog2(MAX_W) + 1;
  localparam int AW = $clog2(MAX_W);

  state_t             state_reg, state_next;
  logic               done_reg, done_next;

  logic [CW-1:0]      img_w_reg;
  logic [15:0]        img_h_reg;
  logic [CW-1:0]      col_reg;
  logic [15:0]        row_reg;
  // Set once the final pixel of the frame has been taken; blocks further input.
  logic               in_done_reg;

  logic               win_valid_reg;
  logic [9*PIX_W-1:0] win_data_reg;

  logic [PIX_W-1:0]   win_reg  [9];
  logic [PIX_W-1:0]   win_next [9];
  logic [PIX_W-1:0]   col_in   [3];
  logic [9*PIX_W-1:0] win_next_packed;

  logic [PIX_W-1:0]   top_rd, mid_rd;

  logic start_ok, pix_acc, win_acc, col_last, last_pix, emit;

  // ---------------------------------------------------------------------
  // Handshake and frame-position decode
  // ---------------------------------------------------------------------
  assign start_ok = start && (state_reg == IDLE) &&
                    (img_w >= CW'(3)) && (img_w <= CW'(MAX_W)) &&
                    (img_h >= 16'd3);

  assign pix_ready = (state_reg == RUN) && !in_done_reg &&
                     (!win_valid_reg || win_ready);
  assign pix_acc   = pix_valid && pix_ready;
  assign win_acc   = win_valid_reg && win_ready;

  assign col_last  = (col_reg == img_w_reg - CW'(1));
  assign last_pix  = col_last && (row_reg == img_h_reg - 16'd1);
  // Only interior pixels (two full rows and two full columns behind them)
  // complete a window.
  assign emit      = pix_acc && (col_reg >= CW'(2)) && (row_reg >= 16'd2);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Once the last pixel is in, the only pending window is the last one,
        // because that pixel could only enter while any older window left.
        if (in_done_reg && win_acc) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;

  // ---------------------------------------------------------------------
  // Position counters and frame dimensions
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_w_reg   <= '0;
      img_h_reg   <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
      in_done_reg <= 1'b0;
    end else if (start_ok) begin
      img_w_reg   <= img_w;
      img_h_reg   <= img_h;
      col_reg     <= '0;
      row_reg     <= '0;
      in_done_reg <= 1'b0;
    end else if (pix_acc) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_reg + 16'd1;
      end else begin
        col_reg <= col_reg + CW'(1);
      end
      if (last_pix) begin
        in_done_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Line buffers: top holds row r-2, mid holds row r-1 at the current column.
  // Each accept pushes the column up by one row.
  // ---------------------------------------------------------------------
  conv_line_buf #(
    .DEPTH (MAX_W),
    .WIDTH (PIX_W)
  ) u_top_buf (
    .clk   (clk),
    .we    (pix_acc),
    .waddr (col_reg[AW-1:0]),
    .wdata (mid_rd),
    .raddr (col_reg[AW-1:0]),
    .rdata (top_rd)
  );

  conv_line_buf #(
    .DEPTH (MAX_W),
    .WIDTH (PIX_W)
  ) u_mid_buf (
    .clk   (clk),
    .we    (pix_acc),
    .waddr (col_reg[AW-1:0]),
    .wdata (pix_data),
    .raddr (col_reg[AW-1:0]),
    .rdata (mid_rd)
  );

  // ---------------------------------------------------------------------
  // 3x3 shift register: each row shifts left, new right column enters.
  // ---------------------------------------------------------------------
  assign col_in[0] = top_rd;
  assign col_in[1] = mid_rd;
  assign col_in[2] = pix_data;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      localparam int L = win_idx(gi, 0);
      assign win_next[L]     = win_reg[L + 1];
      assign win_next[L + 1] = win_reg[L + 2];
      assign win_next[L + 2] = col_in[gi];
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          win_reg[gi] <= '0;
        end else if (pix_acc) begin
          win_reg[gi] <= win_next[gi];
        end
      end
      assign win_next_packed[gi*PIX_W +: PIX_W] = win_next[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output register: loads the freshly shifted window; holds under stall.
  // A load and an accept in the same cycle keep win_valid high.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_reg <= 1'b0;
      win_data_reg  <= '0;
    end else if (emit) begin
      win_valid_reg <= 1'b1;
      win_data_reg  <= win_next_packed;
    end else if (win_acc) begin
      win_valid_reg <= 1'b0;
    end
  end

  assign win_valid = win_valid_reg;
  assign win_data  = win_data_reg;

`ifdef CONV_WIN_PERF_CNT_EN
  logic [31:0] win_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count_reg <= '0;
    end else if (start_ok) begin
      win_count_reg <= '0;
    end else if (win_acc && (win_count_reg != 32'hFFFF_FFFF)) begin
      win_count_reg <= win_count_reg + 32'd1;
    end
  end

  assign win_count = win_count_reg;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen. Expected windows come from a frame-buffer
// model filled as pixels are accepted and are queued until the DUT emits them.
module tb_conv_window_gen;

  localparam int MAX_W = 64;
  localparam int PIX_W = 8;
  localparam int WW    = 9 * PIX_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [$clog2(MAX_W):0] img_w;
  logic [15:0]            img_h;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [PIX_W-1:0]       pix_data;
  logic                   win_valid;
  logic                   win_ready;
  logic [WW-1:0]          win_data;
  logic                   busy;
  logic                   done;
`ifdef CONV_WIN_PERF_CNT_EN
  logic [31:0]            win_count;
`endif

  conv_window_gen #(
    .MAX_W (MAX_W),
    .PIX_W (PIX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_w     (img_w),
    .img_h     (img_h),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .busy      (busy),
    .done      (done)
`ifdef CONV_WIN_PERF_CNT_EN
    ,
    .win_count (win_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0]    exp_q[$];
  logic [PIX_W-1:0] img_mem [0:1023];
  logic [WW-1:0]    first_two [0:1];

  int frame_w, frame_h, base, n_pix, sent;
  int stall_left, done_cnt, win_cnt, gaps, cyc, last_cyc;
  bit stall_en, first_seen;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_window(input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[(3*i+j)*PIX_W +: PIX_W] = img_mem[(r-2+i)*frame_w + (c-2+j)];
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 ns later; both
  // handshakes observed here complete on the following rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (stall_en && !first_seen && win_valid) begin
      first_seen = 1'b1;
      stall_left = 5;
    end
    win_ready = (stall_left == 0);
    pix_valid = (sent < n_pix);
    pix_data  = PIX_W'(base + sent);
    #1;
    if (stall_left > 0) begin
      if (exp_q.size() == 0) check("stall_q", 1, 0);
      else check("stall_data", win_data, exp_q[0]);
      check("stall_pix_ready", {71'd0, pix_ready}, 0);
      stall_left--;
    end
    if (win_valid && win_ready) begin
      if (exp_q.size() == 0) check("extra_win", 1, 0);
      else check("win", win_data, exp_q.pop_front());
      if (win_cnt < 2) first_two[win_cnt] = win_data;
      if (win_cnt > 0 && cyc != last_cyc + 1) gaps++;
      last_cyc = cyc;
      win_cnt++;
    end
    if (done) begin
      done_cnt++;
      check("busy_at_done", {71'd0, busy}, 0);
    end
    if (pix_valid && pix_ready) begin
      img_mem[sent] = pix_data;
      if (sent / frame_w >= 2 && sent % frame_w >= 2)
        exp_q.push_back(exp_window(sent / frame_w, sent % frame_w));
      sent++;
    end
  endtask

  task automatic start_frame(input int w, input int h, input int b, input bit stall, input int npix);
    frame_w = w; frame_h = h; base = b; n_pix = npix; sent = 0;
    stall_en = stall; first_seen = 1'b0; stall_left = 0;
    done_cnt = 0; win_cnt = 0; gaps = 0;
    @(negedge clk);
    img_w = ($clog2(MAX_W)+1)'(w);
    img_h = 16'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int b, input bit stall);
    start_frame(w, h, b, stall, w * h);
    check("busy_after_start", {71'd0, busy}, 1);
    for (int k = 0; k < w * h * 3 + 50 && done_cnt == 0; k++) step();
    for (int k = 0; k < 3; k++) step();
    $display("frame %0dx%0d base=%0d: windows=%0d done_pulses=%0d", w, h, b, win_cnt, done_cnt);
    check("done_once", done_cnt, 1);
    check("win_total", win_cnt, (w - 2) * (h - 2));
    check("queue_empty", exp_q.size(), 0);
    check("busy_after_done", {71'd0, busy}, 0);
`ifdef CONV_WIN_PERF_CNT_EN
    check("win_count", {40'd0, win_count}, (w - 2) * (h - 2));
`endif
    @(negedge clk);
    pix_valid = 1'b1;
    #1;
    check("pix_ready_idle", {71'd0, pix_ready}, 0);
    pix_valid = 1'b0;
  endtask

  task automatic bad_start(input int w, input int h);
    start_frame(w, h, 0, 1'b0, 0);
    check("bad_busy", {71'd0, busy}, 0);
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    pix_valid = 1'b1;
    #1;
    $display("bad start %0dx%0d: busy=%0b pix_ready=%0b done_pulses=%0d", w, h, busy, pix_ready, done_cnt);
    check("bad_pix_ready", {71'd0, pix_ready}, 0);
    check("bad_done", done_cnt, 0);
    pix_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; img_w = '0; img_h = '0;
    pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
    cyc = 0; last_cyc = 0; sent = 0; n_pix = 0; frame_w = 1;
    #3;
    check("rst_win_valid", {71'd0, win_valid}, 0);
    check("rst_win_data", win_data, 0);
    check("rst_busy", {71'd0, busy}, 0);
    check("rst_done", {71'd0, done}, 0);
    check("rst_pix_ready", {71'd0, pix_ready}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 4x3 frame, pixels 1..12, no stall
    run_frame(4, 3, 1, 1'b0);
    check("w0_const", first_two[0], 72'h0b0a09070605030201);
    check("w1_const", first_two[1], 72'h0c0b0a080706040302);

    // same frame, output stalled for 5 cycles after the first window
    run_frame(4, 3, 1, 1'b1);
    check("stall_w0_const", first_two[0], 72'h0b0a09070605030201);
    check("stall_w1_const", first_two[1], 72'h0c0b0a080706040302);

    // illegal dimensions are ignored
    bad_start(2, 5);
    bad_start(5, 2);
    bad_start(MAX_W + 1, 3);

    // reset mid-frame after 7 pixels
    start_frame(5, 5, 40, 1'b0, 7);
    for (int k = 0; k < 60 && sent < 7; k++) step();
    check("abort_sent", sent, 7);
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_win_valid", {71'd0, win_valid}, 0);
    check("abort_win_data", win_data, 0);
    check("abort_busy", {71'd0, busy}, 0);
    check("abort_pix_ready", {71'd0, pix_ready}, 0);
    check("abort_done", {71'd0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    done_cnt = 0; n_pix = 0; sent = 0;
    for (int k = 0; k < 3; k++) step();
    check("abort_no_done", done_cnt, 0);

    // two back-to-back 5x5 frames
    run_frame(5, 5, 100, 1'b0);
    run_frame(5, 5, 150, 1'b0);

    // full-width, 3-row frame: windows on consecutive cycles
    run_frame(MAX_W, 3, 7, 1'b0);
    check("wide_gaps", gaps, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
